// File: rtl/alu_result_fifo.sv
// alu_result_fifo: capture stage for the 3-bit ALU result {cout, y}.
// Each push/pop pin strobe is synchronised and edge-detected into a one-cycle
// pulse. Accepted words are queued in a small FIFO and shown at the head.
//
// Optional feature: define ALU_FIFO_CHECKSUM_EN to build a running sum of
// every accepted pushed word on sum_out. Without it, sum_out is tied to 0.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   ena         block enable; low freezes FIFO state (strobe path keeps running)
//   y_in        ALU result Y[2:0]
//   cout_in     ALU carry out
//   push_req    push strobe pin (asynchronous level)
//   pop_req     pop strobe pin (asynchronous level)
//   head_data   word at the FIFO head, 0 when empty
//   head_valid  FIFO not empty
//   count       occupancy 0..DEPTH
//   full/empty  decoded from count
//   overflow    sticky: a push was dropped while full
//   sum_out     checksum of accepted pushes (0 when feature not built)
module alu_result_fifo #(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [2:0]                 y_in,
    input  logic                       cout_in,
    input  logic                       push_req,
    input  logic                       pop_req,
    output logic [DATA_W-1:0]          head_data,
    output logic                       head_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic [DATA_W+1:0]          sum_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = DATA_W + 2;

    // Strobe synchronisers and rising-edge detectors
    logic [SYNC_STAGES-1:0] push_sync_q;
    logic [SYNC_STAGES-1:0] pop_sync_q;
    logic                   push_prev_q;
    logic                   pop_prev_q;
    logic                   push_pulse;
    logic                   pop_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_sync_q <= '0;
            pop_sync_q  <= '0;
            push_prev_q <= 1'b0;
            pop_prev_q  <= 1'b0;
        end else begin
            push_sync_q <= {push_sync_q[SYNC_STAGES-2:0], push_req};
            pop_sync_q  <= {pop_sync_q[SYNC_STAGES-2:0], pop_req};
            push_prev_q <= push_sync_q[SYNC_STAGES-1];
            pop_prev_q  <= pop_sync_q[SYNC_STAGES-1];
        end
    end

    assign push_pulse = push_sync_q[SYNC_STAGES-1] & ~push_prev_q;
    assign pop_pulse  = pop_sync_q[SYNC_STAGES-1] & ~pop_prev_q;

    // FIFO state
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push_acc;
    logic              pop_acc;
    logic [DATA_W-1:0] wdata;

    assign wdata = DATA_W'({cout_in, y_in});
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Pop needs data; a push into a full FIFO is only legal if a pop frees a slot
    assign pop_acc  = ena & pop_pulse & ~empty;
    assign push_acc = ena & push_pulse & (~full | pop_acc);

    // Next-state for pointers, count and sticky overflow
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (ena && push_pulse && !push_acc) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; head_data is masked while empty
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign head_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign head_valid = ~empty;
    assign count      = count_q;
    assign overflow   = overflow_q;

`ifdef ALU_FIFO_CHECKSUM_EN
    // Running sum of accepted pushes, wraps modulo 2^SW
    logic [SW-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (push_acc) begin
            sum_d = sum_q + SW'(wdata);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_out = sum_q;
`else
    assign sum_out = '0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: a queue-based reference model driven by the pin
// history, compared every cycle, plus directed checks with literal values.
module tb_alu_result_fifo;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int SYNC   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [2:0] y_in = '0;
    logic       cout_in = 1'b0;
    logic       push_req = 1'b0;
    logic       pop_req = 1'b0;
    logic [DATA_W-1:0] head_data;
    logic       head_valid;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [DATA_W+1:0] sum_out;

    int n_cmp = 0;
    int n_bad = 0;

    alu_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .ena(ena), .y_in(y_in), .cout_in(cout_in),
        .push_req(push_req), .pop_req(pop_req), .head_data(head_data),
        .head_valid(head_valid), .count(count), .full(full), .empty(empty),
        .overflow(overflow), .sum_out(sum_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pin level seen at edge k produces an event at edge
    // k+SYNC if the level at edge k-1 was low. Events are consumed only when
    // ena is high at the event edge; data is taken at that edge.
    int unsigned m_q[$];
    int          m_sum = 0;
    bit          m_ovf = 1'b0;
    bit          ph[8];
    bit          qh[8];

    task automatic model_clear();
        m_q.delete();
        m_sum = 0;
        m_ovf = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ph[i] = 1'b0;
            qh[i] = 1'b0;
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_clear();
            end else begin
                bit pe, qe, pop_ok, push_ok;
                // ph[i] = push_req level seen i edges ago
                pe = ph[SYNC] & ~ph[SYNC+1];
                qe = qh[SYNC] & ~qh[SYNC+1];
                if (ena) begin
                    pop_ok  = qe && (m_q.size() > 0);
                    push_ok = pe && ((m_q.size() < DEPTH) || pop_ok);
                    if (pe && !push_ok) m_ovf = 1'b1;
                    if (pop_ok) void'(m_q.pop_front());
                    if (push_ok) begin
                        m_q.push_back({cout_in, y_in});
                        m_sum = (m_sum + int'({cout_in, y_in})) % 64;
                    end
                end
                for (int i = 7; i > 1; i--) begin
                    ph[i] = ph[i-1];
                    qh[i] = qh[i-1];
                end
                ph[1] = push_req;
                qh[1] = pop_req;
            end
        end
    end

    function automatic int exp_sum();
`ifdef ALU_FIFO_CHECKSUM_EN
        return m_sum;
`else
        return 0;
`endif
    endfunction

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("m_count", int'(count), m_q.size());
            chk("m_head", int'(head_data), (m_q.size() > 0) ? int'(m_q[0]) : 0);
            chk("m_valid", int'(head_valid), int'(m_q.size() > 0));
            chk("m_full", int'(full), int'(m_q.size() == DEPTH));
            chk("m_empty", int'(empty), int'(m_q.size() == 0));
            chk("m_ovf", int'(overflow), int'(m_ovf));
            chk("m_sum", int'(sum_out), exp_sum());
        end
    end

    task automatic set_data(input logic [3:0] d);
        cout_in = d[3];
        y_in    = d[2:0];
    endtask

    task automatic strobe(input bit do_push, input bit do_pop, input logic [3:0] d, input int hold);
        @(negedge clk);
        set_data(d);
        push_req = do_push;
        pop_req  = do_pop;
        repeat (hold) @(negedge clk);
        push_req = 1'b0;
        pop_req  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_word(input logic [3:0] d);
        strobe(1'b1, 1'b0, d, 3);
    endtask

    task automatic pop_word();
        strobe(1'b0, 1'b1, 4'h0, 3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        push_req = 1'b0;
        pop_req  = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_head", int'(head_data), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: long strobe gives one push of 4'b1101
        strobe(1'b1, 1'b0, 4'b1101, 5);
        repeat (2) @(negedge clk);
        chk("t1_count", int'(count), 1);
        chk("t1_head", int'(head_data), 4'b1101);
        chk("t1_valid", int'(head_valid), 1);
        chk("t1_empty", int'(empty), 0);

        // 2: fill, overflow, drain
        do_reset();
        for (int i = 1; i <= 5; i++) push_word(4'(i));
        chk("t2_full", int'(full), 1);
        chk("t2_count", int'(count), 4);
        chk("t2_ovf", int'(overflow), 1);
        chk("t2_head", int'(head_data), 1);
        for (int i = 1; i <= 4; i++) begin
            chk("t2_pop_head", int'(head_data), i);
            pop_word();
        end
        chk("t2_empty", int'(empty), 1);
        chk("t2_head0", int'(head_data), 0);
        chk("t2_ovf_sticky", int'(overflow), 1);

        // 3: simultaneous push/pop while full
        do_reset();
        for (int i = 1; i <= 4; i++) push_word(4'(i));
        strobe(1'b1, 1'b1, 4'h7, 3);
        chk("t3_count", int'(count), 4);
        chk("t3_ovf", int'(overflow), 0);
        chk("t3_head", int'(head_data), 2);
        chk("t3_p0", int'(head_data), 2); pop_word();
        chk("t3_p1", int'(head_data), 3); pop_word();
        chk("t3_p2", int'(head_data), 4); pop_word();
        chk("t3_p3", int'(head_data), 7); pop_word();
        chk("t3_empty", int'(empty), 1);

        // 4: simultaneous push/pop while empty, then pop on empty
        strobe(1'b1, 1'b1, 4'hA, 3);
        chk("t4_count", int'(count), 1);
        chk("t4_head", int'(head_data), 4'hA);
        pop_word();
        pop_word();
        chk("t4_count0", int'(count), 0);
        chk("t4_ovf", int'(overflow), 0);

        // 5: ena low discards pulses; re-enabling under a held strobe is silent
        push_word(4'h5);
        ena = 1'b0;
        push_word(4'h6);
        pop_word();
        chk("t5_count_frozen", int'(count), 1);
        @(negedge clk);
        push_req = 1'b1;
        repeat (4) @(negedge clk);
        ena = 1'b1;
        repeat (4) @(negedge clk);
        push_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_count_held", int'(count), 1);
        chk("t5_head", int'(head_data), 5);

        // 6: checksum of five 4'hF pushes, then async reset mid-push at count 3
        do_reset();
        for (int i = 0; i < 5; i++) push_word(4'hF);
`ifdef ALU_FIFO_CHECKSUM_EN
        chk("t6_sum", int'(sum_out), 60);
`else
        chk("t6_sum", int'(sum_out), 0);
`endif
        pop_word();
        chk("t6_count3", int'(count), 3);
        @(negedge clk);
        set_data(4'h9);
        push_req = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_count", int'(count), 0);
        chk("t6_rst_head", int'(head_data), 0);
        chk("t6_rst_valid", int'(head_valid), 0);
        chk("t6_rst_empty", int'(empty), 1);
        chk("t6_rst_full", int'(full), 0);
        chk("t6_rst_ovf", int'(overflow), 0);
        chk("t6_rst_sum", int'(sum_out), 0);
        push_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_after_count", int'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
